// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
//  Module      : hazard_ctrl_pkg
//  Description : Shared types and constants for the pipeline hazard control
//                block. Holds the FSM state enum, the register-address width
//                and the x0 register address.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

  // Encoding 2'd3 is never produced; the controller decodes it as RUN.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    MDU_ERR  = 2'd2
  } hazard_state_e;

endpackage

`default_nettype wire

// File: rtl/hazard_load_use_detect.sv
// ============================================================================
//  Module      : hazard_load_use_detect
//  Description : Combinational load-use hazard comparator. Flags when the
//                instruction in EX is a load writing a non-x0 register that
//                the instruction in ID reads.
//  Ports       : i_id_rs1/i_id_rs2      - source registers of the ID instr
//                i_id_uses_rs1/_rs2     - ID instr actually reads rs1/rs2
//                i_ex_rd                - destination register of EX instr
//                i_ex_mem_read          - EX instr is a load
//                o_load_use             - load-use hazard present
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_load_use_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_uses_rs1,
  input  logic                  i_id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_mem_read,
  output logic                  o_load_use
);

  logic w_rs1_match;
  logic w_rs2_match;

  assign w_rs1_match = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_rs2_match = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);

  // A load into x0 produces nothing to forward, so it never stalls.
  assign o_load_use  = i_ex_mem_read && (i_ex_rd != X0) && (w_rs1_match || w_rs2_match);

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Pipeline hazard controller. Generates stall/flush controls
//                for load-use hazards, taken control transfers and multi-
//                cycle MDU operations, with a watchdog on the MDU wait.
//  Parameters  : MDU_MAX_CYCLES - watchdog limit in MDU_WAIT cycles
//  Macro       : HAZARD_PERF_EN - adds STALL_COUNT / FLUSH_COUNT outputs
//  Ports       : CLK, RESET (async, active-high)
//                ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2 - ID operands
//                EX_RD, EX_MEM_READ                       - EX load info
//                EX_BRANCH_TAKEN                          - taken transfer
//                EX_MDU_START, MDU_DONE                   - MDU handshake
//                PC_ENABLE, IF_ID_ENABLE, IF_ID_FLUSH,
//                ID_EX_ENABLE, ID_EX_FLUSH, EX_MEM_FLUSH  - pipe controls
//                MDU_ERROR                                - sticky watchdog
//                STATE                                    - FSM state
//                STALL_COUNT, FLUSH_COUNT (HAZARD_PERF_EN only)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MDU_MAX_CYCLES = 40
)
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [REG_ADDR_W-1:0] ID_RS1,
  input  logic [REG_ADDR_W-1:0] ID_RS2,
  input  logic                  ID_USES_RS1,
  input  logic                  ID_USES_RS2,
  input  logic [REG_ADDR_W-1:0] EX_RD,
  input  logic                  EX_MEM_READ,
  input  logic                  EX_BRANCH_TAKEN,
  input  logic                  EX_MDU_START,
  input  logic                  MDU_DONE,
  output logic                  PC_ENABLE,
  output logic                  IF_ID_ENABLE,
  output logic                  IF_ID_FLUSH,
  output logic                  ID_EX_ENABLE,
  output logic                  ID_EX_FLUSH,
  output logic                  EX_MEM_FLUSH,
  output logic                  MDU_ERROR,
  output logic [1:0]            STATE
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           STALL_COUNT,
  output logic [31:0]           FLUSH_COUNT
`endif
);

  localparam int CNT_W = (MDU_MAX_CYCLES < 1) ? 1 : $clog2(MDU_MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MDU_MAX_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  hazard_state_e    r_state;
  hazard_state_e    w_state_next;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_cnt_next;
  logic [CNT_W-1:0] w_wait_cnt_inc;
  logic             r_mdu_error;
  logic             w_mdu_error_next;
  logic             w_load_use;
  logic             w_is_err;

  hazard_load_use_detect u_load_use (
    .i_id_rs1      (ID_RS1),
    .i_id_rs2      (ID_RS2),
    .i_id_uses_rs1 (ID_USES_RS1),
    .i_id_uses_rs2 (ID_USES_RS2),
    .i_ex_rd       (EX_RD),
    .i_ex_mem_read (EX_MEM_READ),
    .o_load_use    (w_load_use)
  );

  // Saturating increment: the counter parks at all-ones instead of wrapping.
  assign w_wait_cnt_inc = (r_wait_cnt == {CNT_W{1'b1}}) ? r_wait_cnt : (r_wait_cnt + CNT_ONE);
  assign w_is_err       = (r_state == MDU_ERR);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_mdu_error <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_wait_cnt  <= w_wait_cnt_next;
      r_mdu_error <= w_mdu_error_next;
    end
  end

  always_comb begin
    // MDU_ERR is terminal until reset; everything else (including the
    // unreachable encoding 3) falls back to RUN unless a branch below says so.
    w_state_next     = w_is_err ? MDU_ERR : RUN;
    w_wait_cnt_next  = r_wait_cnt;
    w_mdu_error_next = r_mdu_error;
    PC_ENABLE        = 1'b1;
    IF_ID_ENABLE     = 1'b1;
    IF_ID_FLUSH      = 1'b0;
    ID_EX_ENABLE     = 1'b1;
    ID_EX_FLUSH      = 1'b0;
    EX_MEM_FLUSH     = 1'b0;

    if (!RESET) begin
      if (r_state == MDU_WAIT) begin
        // Branches and load-use are irrelevant here: the front end is frozen.
        if (!MDU_DONE) begin
          PC_ENABLE       = 1'b0;
          IF_ID_ENABLE    = 1'b0;
          ID_EX_ENABLE    = 1'b0;
          EX_MEM_FLUSH    = 1'b1;
          w_wait_cnt_next = w_wait_cnt_inc;
          if (w_wait_cnt_inc == CNT_LIMIT) begin
            w_state_next     = MDU_ERR;
            w_mdu_error_next = 1'b1;
          end else begin
            w_state_next     = MDU_WAIT;
          end
        end
      end else if (!w_is_err && EX_MDU_START && !MDU_DONE) begin
        // Multi-cycle MDU op: freeze the front end starting this very cycle.
        PC_ENABLE       = 1'b0;
        IF_ID_ENABLE    = 1'b0;
        ID_EX_ENABLE    = 1'b0;
        EX_MEM_FLUSH    = 1'b1;
        w_wait_cnt_next = '0;
        w_state_next    = MDU_WAIT;
      end else if (EX_BRANCH_TAKEN) begin
        // The stalled ID instruction is on the wrong path anyway, so the
        // redirect wins over any load-use stall.
        IF_ID_FLUSH = 1'b1;
        ID_EX_FLUSH = 1'b1;
      end else if (w_load_use) begin
        PC_ENABLE    = 1'b0;
        IF_ID_ENABLE = 1'b0;
        ID_EX_FLUSH  = 1'b1;
      end
    end
  end

  assign MDU_ERROR = r_mdu_error;
  assign STATE     = r_state;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!PC_ENABLE && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (IF_ID_FLUSH && (r_flush_cnt != 32'hFFFF_FFFF)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign STALL_COUNT = r_stall_cnt;
  assign FLUSH_COUNT = r_flush_cnt;
`endif

endmodule

`default_nettype wire
